// File: rtl/btb_pkg.sv
// Shared types, default geometry and counter helpers for the set-associative BTB.
package btb_pkg;
  localparam int PC_W_DEF    = 16;
  localparam int SETS_DEF    = 256;
  localparam int WAYS_DEF    = 2;
  localparam int CTR_W_DEF   = 2;
  localparam int INDEX_W_DEF = $clog2(SETS_DEF);
  localparam int TAG_W_DEF   = PC_W_DEF - INDEX_W_DEF;

  localparam logic [CTR_W_DEF-1:0] CTR_WEAK_T = CTR_W_DEF'(1 << (CTR_W_DEF - 1));

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [CTR_W_DEF-1:0] ctr;
    logic [PC_W_DEF-1:0]  target;
  } btb_entry_t;

  // Counters are carried in 8 bits so one helper serves any CTR_W up to 7.
  function automatic logic [7:0] sat_inc(input logic [7:0] c, input int w);
    logic [7:0] mx;
    mx = 8'((1 << w) - 1);
    return (c >= mx) ? c : c + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] c);
    return (c == 8'd0) ? c : c - 8'd1;
  endfunction
endpackage

// File: rtl/btb_sa_set_ram.sv
// Per-set storage (all ways + victim pointer), two synchronous read ports, one write port.
module btb_sa_set_ram
  import btb_pkg::*;
#(
  parameter int SETS = SETS_DEF,
  parameter int W    = 8,
  localparam int IW  = $clog2(SETS)
) (
  input  logic          clk,
  input  logic [IW-1:0] rd_a_idx,
  output logic [W-1:0]  rd_a_data,
  input  logic [IW-1:0] rd_b_idx,
  output logic [W-1:0]  rd_b_data,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data
);
  logic [W-1:0] mem_q [SETS];

  // Reads sample the array before this edge's write lands: read-old on collision.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_idx] <= wr_data;
    rd_a_data <= mem_q[rd_a_idx];
    rd_b_data <= mem_q[rd_b_idx];
  end
endmodule

// File: rtl/btb_sa.sv
// Set-associative BTB: 1-cycle lookup, 2-stage read/modify/write update, clear-sweep FSM.
module btb_sa
  import btb_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int SETS  = SETS_DEF,
  parameter int WAYS  = WAYS_DEF,
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_hit,
  output logic            lk_taken,
  output logic [PC_W-1:0] lk_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic            ready
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = PC_W - INDEX_W;
  localparam int WAY_W   = $clog2(WAYS);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [CTR_W-1:0] ctr;
    logic [PC_W-1:0]  target;
  } ent_t;

  typedef struct packed {
    ent_t [WAYS-1:0]  way;
    logic [WAY_W-1:0] vptr;
  } set_t;

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic               ready_q, ready_d, lk_ok_q, lk_ok_d;
  logic [TAG_W-1:0]   lk_tag_q, lk_tag_d;
  logic               s1_vld_q, s1_vld_d, s1_taken_q, s1_taken_d;
  logic [PC_W-1:0]    s1_pc_q, s1_pc_d, s1_target_q, s1_target_d;
  logic               fwd_q, fwd_d;
  set_t               fwd_set_q, fwd_set_d;

  set_t               lk_set, up_set_raw, up_set, upd_set, wr_set;
  logic               we, upd_we;
  logic [INDEX_W-1:0] wr_idx;
  logic [TAG_W-1:0]   s1_tag;

  btb_sa_set_ram #(.SETS(SETS), .W($bits(set_t))) u_ram (
    .clk      (clk),
    .rd_a_idx (lk_pc[INDEX_W-1:0]),
    .rd_a_data(lk_set),
    .rd_b_idx (upd_pc[INDEX_W-1:0]),
    .rd_b_data(up_set_raw),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_data  (wr_set)
  );

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      ST_SWEEP: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == INDEX_W'(SETS - 1)) state_d = ST_RUN;
      end
      default: ;
    endcase
    if (flush) begin
      state_d     = ST_SWEEP;
      sweep_idx_d = '0;
    end
    ready_d = (state_d == ST_RUN);
  end

  // Lookup: lowest matching way wins; outputs held at zero unless sampled while ready.
  always_comb begin
    lk_ok_d   = ready_q & ~flush;
    lk_tag_d  = lk_pc[PC_W-1:INDEX_W];
    lk_hit    = 1'b0;
    lk_taken  = 1'b0;
    lk_target = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_set.way[w].valid && lk_set.way[w].tag == lk_tag_q) begin
        lk_hit    = 1'b1;
        lk_taken  = lk_set.way[w].ctr[CTR_W-1];
        lk_target = lk_set.way[w].target;
      end
    end
    if (!lk_ok_q) begin
      lk_hit    = 1'b0;
      lk_taken  = 1'b0;
      lk_target = '0;
    end
  end

  // Update S2: compare against forwarded or array data, build the new set image.
  always_comb begin
    s1_vld_d    = upd_valid & ready_q & ~flush;
    s1_pc_d     = upd_pc;
    s1_taken_d  = upd_taken;
    s1_target_d = upd_target;
    s1_tag      = s1_pc_q[PC_W-1:INDEX_W];
    up_set      = fwd_q ? fwd_set_q : up_set_raw;
    upd_set     = up_set;
    upd_we      = 1'b0;
    begin : s2
      logic             hit, inv;
      logic [WAY_W-1:0] hway, iway, vway;
      hit  = 1'b0;
      inv  = 1'b0;
      hway = '0;
      iway = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (up_set.way[w].valid && up_set.way[w].tag == s1_tag) begin
          hit  = 1'b1;
          hway = WAY_W'(w);
        end
        if (!up_set.way[w].valid) begin
          inv  = 1'b1;
          iway = WAY_W'(w);
        end
      end
      vway = inv ? iway : up_set.vptr;
      if (hit) begin
        upd_we = 1'b1;
        if (s1_taken_q) begin
          upd_set.way[hway].ctr    = CTR_W'(sat_inc(8'(up_set.way[hway].ctr), CTR_W));
          upd_set.way[hway].target = s1_target_q;
        end else begin
          upd_set.way[hway].ctr = CTR_W'(sat_dec(8'(up_set.way[hway].ctr)));
        end
      end else if (s1_taken_q) begin
        upd_we                   = 1'b1;
        upd_set.way[vway].valid  = 1'b1;
        upd_set.way[vway].tag    = s1_tag;
        upd_set.way[vway].ctr    = CTR_WEAK;
        upd_set.way[vway].target = s1_target_q;
        if (!inv) upd_set.vptr = up_set.vptr + 1'b1;
      end
    end
  end

  always_comb begin
    if (state_q == ST_SWEEP) begin
      we     = ~rst;
      wr_idx = sweep_idx_q;
      wr_set = '0;
    end else begin
      we     = s1_vld_q & upd_we & ~flush & ~rst;
      wr_idx = s1_pc_q[INDEX_W-1:0];
      wr_set = upd_set;
    end
    fwd_d     = we & (wr_idx == upd_pc[INDEX_W-1:0]);
    fwd_set_d = wr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SWEEP;
      sweep_idx_q <= '0;
      ready_q     <= 1'b0;
      lk_ok_q     <= 1'b0;
      s1_vld_q    <= 1'b0;
      fwd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ready_q     <= ready_d;
      lk_ok_q     <= lk_ok_d;
      s1_vld_q    <= s1_vld_d;
      fwd_q       <= fwd_d;
    end
    lk_tag_q    <= lk_tag_d;
    s1_pc_q     <= s1_pc_d;
    s1_taken_q  <= s1_taken_d;
    s1_target_q <= s1_target_d;
    fwd_set_q   <= fwd_set_d;
  end

  assign ready = ready_q;
endmodule

// File: doc/btb_sa.md
Name: btb_sa

Overview:
Parametrised set-associative branch target buffer with 2-bit saturating direction counters, for the IF-stage next-PC mux. Lookup uses the fetch PC. Update is driven from EX with the resolved outcome of the branch's own PC. A hardware sweep FSM clears all valid bits at reset or flush, so no memory-init file is needed.

Parameters:
PC_W, 16, PC/target width
SETS, 256, number of sets (power of 2); INDEX_W = $clog2(SETS), TAG_W = PC_W - INDEX_W
WAYS, 2, associativity (power of 2, >=2); WAY_W = $clog2(WAYS)
CTR_W, 2, direction counter width

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
flush  in  1  single-cycle pulse; invalidate entire BTB
lk_pc  in  PC_W  fetch PC to look up
lk_hit  out  1  tag match in a valid way (registered)
lk_taken  out  1  hit & counter MSB set
lk_target  out  PC_W  predicted target (0 on miss)
upd_valid  in  1  resolved branch present in EX
upd_pc  in  PC_W  PC of the branch itself (not incremented)
upd_taken  in  1  actual direction
upd_target  in  PC_W  actual target
ready  out  1  sweep complete; BTB operational

Behaviour:
- Address split: index = pc[INDEX_W-1:0]; tag = pc[PC_W-1:INDEX_W]. Entry = {valid, tag, ctr, target}. Each set also holds a WAY_W round-robin victim pointer.
- Reset values: lk_hit=0, lk_taken=0, lk_target=0, ready=0, FSM=SWEEP, sweep_idx=0, update pipe empty.
- FSM SWEEP:
  - Each cycle, clear valid bits and the victim pointer of set sweep_idx, then increment sweep_idx.
  - After set SETS-1 is cleared, go to RUN; ready=1 from the next cycle.
  - Sweep takes exactly SETS cycles after rst deasserts.
- FSM RUN: flush=1 returns to SWEEP with sweep_idx=0 and ready=0. rst has the same effect at any time.
- Lookup latency 1:
  - lk_pc is sampled at edge N; outputs are valid after edge N.
  - Hit means any way is valid with a tag match. If several ways match, the lowest way index wins.
  - While ready=0, outputs are forced to hit=0, taken=0, target=0.
- Update, 2-stage pipeline:
  - S1 (edge N): read the set for upd_pc and tag-compare.
  - S2 (edge N+1): write the set.
  - A lookup sampled at edge N+2 or later sees the new data.
  - A lookup to the same set in the same cycle as the S2 write returns the old data (read-old).
- Update rules, applied only when upd_valid & ready:
  - Hit in way w, taken: ctr = sat_inc(ctr); target = upd_target.
  - Hit in way w, not-taken: ctr = sat_dec(ctr); the entry stays valid.
  - Miss, taken: allocate. Victim is the lowest invalid way, else the victim pointer. Write valid=1, tag, ctr = 2'b10 (weak taken; generally 1<<(CTR_W-1)), target. Victim pointer increments mod WAYS only on allocate from a full set.
  - Miss, not-taken: no write.
- Counters saturate at 0 and 2^CTR_W-1 and never wrap.
- Hazard: if the S2 write targets the same index as the S1 read of the following update, S1 takes the forwarded S2 entry and victim pointer, not the array data. Back-to-back updates to the same branch must accumulate.
- Updates in S1/S2 when flush or rst asserts are discarded. An upd_valid arriving while ready=0 is ignored.

Decomposition:
- Package btb_pkg: PC_W default, btb_entry_t struct {valid, tag, ctr, target}, CTR_WEAK_T constant, sat_inc/sat_dec functions.
- One sub-module, btb_set_ram: SETS-deep, synchronous-read memory holding WAYS entries plus victim pointer per set. It has one read port for lookup, one read port for update S1, and one write port.
- FSM, compare, and forwarding live in the top level.

Test Plan:
- Reset sweep: pulse rst, hold lk_pc=0x0040 -> ready=0 and lk_hit=0 for exactly 256 cycles, ready=1 on cycle 257.
- Allocate/predict: upd pc=0x1234 taken target=0x2000; then lookup 0x1234 two cycles later -> hit=1, taken=1 (ctr=10), target=0x2000. Lookup 0x1235 -> hit=0.
- Counter saturation: 3 taken updates -> ctr=11. Then 2 not-taken -> ctr=01, lookup hit=1, taken=0. 2 more not-taken -> ctr=00, still hit=1, taken=0.
- Replacement: taken updates to 0x0105, 0x0205, 0x0305 (same set 0x05) -> third evicts way 0 (0x0105 misses); a fourth update 0x0405 evicts way 1 (0x0205 misses).
- Forwarding: back-to-back upd_valid cycles, pc=0x0A10 taken then taken (ctr 10 -> 11) -> lookup shows taken=1, ctr=11, a single valid way, no duplicate allocation.
- Flush mid-update: update 0x0777 taken with flush in the S2 cycle -> after the 256-cycle re-sweep, lookup 0x0777 returns hit=0.
